// File: rtl/l2_input_arbiter_param.sv
// l2_input_arbiter_param: N_CH-way valid/ready arbiter with ageing and a set/way flush walker
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   decode_en        arbitration/update enable; low freezes all state
//   in_valid/in_block/in_addr  per-channel request, stall and address (channel i at [i*ADDR_W +: ADDR_W])
//   in_ready         combinational one-hot accept for the winning channel
//   flush_start/flush_ready    flush request and its combinational accept
//   flush_active     walker is running; flush_done one-cycle pulse after the last op
//   grant_*          registered operation: valid, one-hot channel, flush flag, tag, set, way
//   starve_boost     registered: grant came from the ageing override
//   idle             combinational: decode_en high and nothing selected
module l2_input_arbiter_param #(
   parameter int N_CH       = 4,
   parameter int ADDR_W     = 32,
   parameter int OFF_BITS   = 4,
   parameter int SET_BITS   = 8,
   parameter int WAYS       = 8,
   parameter int FLUSH_PRIO = 2,
   parameter int STARVE_MAX = 15
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 decode_en,
   input  logic [N_CH-1:0]                      in_valid,
   input  logic [N_CH-1:0]                      in_block,
   input  logic [N_CH*ADDR_W-1:0]               in_addr,
   output logic [N_CH-1:0]                      in_ready,
   input  logic                                 flush_start,
   output logic                                 flush_ready,
   output logic                                 flush_active,
   output logic                                 flush_done,
   output logic                                 grant_valid,
   output logic [N_CH-1:0]                      grant_ch,
   output logic                                 grant_flush,
   output logic [ADDR_W-OFF_BITS-SET_BITS-1:0]  grant_tag,
   output logic [SET_BITS-1:0]                  grant_set,
   output logic [$clog2(WAYS)-1:0]              grant_way,
   output logic                                 starve_boost,
   output logic                                 idle
);
   localparam int TAG_W = ADDR_W - OFF_BITS - SET_BITS;
   localparam int WAY_W = $clog2(WAYS);
   localparam int AGE_W = $clog2(STARVE_MAX + 1);
   typedef enum logic {S_IDLE, S_FLUSH} state_t;
   state_t r_state, w_state_nxt;
   logic [SET_BITS-1:0] r_set, w_set_nxt, r_grant_set;
   logic [WAY_W-1:0] r_way, w_way_nxt, r_grant_way;
   logic [AGE_W-1:0] r_age [N_CH];
   logic [N_CH-1:0] w_elig, w_boost_vec, w_elig_oh, w_boost_oh, w_win, r_grant_ch;
   logic [TAG_W-1:0] r_grant_tag;
   logic [ADDR_W-1:0] w_addr;
   logic w_boost, w_accept, w_flush_op, w_last_op, w_way_wrap;
   logic r_grant_valid, r_grant_flush, r_boost, r_flush_done;
   logic w_unused;
   always_comb begin
      w_elig = '0;
      w_boost_vec = '0;
      for (int i = 0; i < N_CH; i++) begin
         // while flushing only the high-priority channels may cut in
         w_elig[i] = in_valid[i] & ~in_block[i] & (r_state == S_IDLE || i < FLUSH_PRIO);
         w_boost_vec[i] = w_elig[i] & (r_age[i] == AGE_W'(STARVE_MAX));
      end
      // isolate the lowest set bit = lowest-index request
      w_elig_oh = w_elig & (~w_elig + N_CH'(1));
      w_boost_oh = w_boost_vec & (~w_boost_vec + N_CH'(1));
      w_boost = decode_en & |w_boost_vec;
      w_accept = decode_en & ~w_boost & flush_start & (r_state == S_IDLE);
      w_win = (!decode_en || w_accept) ? '0 : w_boost ? w_boost_oh : w_elig_oh;
      w_flush_op = decode_en & ~w_accept & ~|w_win & (r_state == S_FLUSH);
      w_way_wrap = r_way == WAY_W'(WAYS - 1);
      w_last_op = w_flush_op & w_way_wrap & (r_set == '1);
      w_addr = '0;
      for (int i = 0; i < N_CH; i++)
         if (w_win[i]) w_addr = in_addr[i*ADDR_W +: ADDR_W];
      w_state_nxt = w_accept ? S_FLUSH : w_last_op ? S_IDLE : r_state;
      w_way_nxt = w_accept ? '0 : w_flush_op ? (w_way_wrap ? '0 : r_way + WAY_W'(1)) : r_way;
      // the set counter wraps to 0 by itself after the last set
      w_set_nxt = w_accept ? '0 : (w_flush_op && w_way_wrap) ? r_set + SET_BITS'(1) : r_set;
   end
   assign w_unused = ^w_addr[OFF_BITS-1:0];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_set <= '0;
         r_way <= '0;
         r_flush_done <= 1'b0;
         r_grant_valid <= 1'b0;
         r_grant_ch <= '0;
         r_grant_flush <= 1'b0;
         r_grant_tag <= '0;
         r_grant_set <= '0;
         r_grant_way <= '0;
         r_boost <= 1'b0;
         for (int i = 0; i < N_CH; i++) r_age[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_set <= w_set_nxt;
         r_way <= w_way_nxt;
         r_flush_done <= w_last_op;
         if (decode_en) begin
            r_grant_valid <= |w_win | w_flush_op;
            r_grant_ch <= w_win;
            r_grant_flush <= w_flush_op;
            r_grant_tag <= w_addr[ADDR_W-1 -: TAG_W];
            r_grant_set <= w_flush_op ? r_set : w_addr[OFF_BITS +: SET_BITS];
            r_grant_way <= w_flush_op ? r_way : '0;
            r_boost <= w_boost;
            // blocked or flush-masked requesters hold their age
            for (int i = 0; i < N_CH; i++)
               r_age[i] <= (!in_valid[i] || w_win[i]) ? '0 :
                           (w_elig[i] && r_age[i] != AGE_W'(STARVE_MAX)) ? r_age[i] + AGE_W'(1) : r_age[i];
         end
      end
   end
   assign in_ready = w_win;
   assign flush_ready = w_accept;
   assign flush_active = r_state == S_FLUSH;
   assign flush_done = r_flush_done;
   assign grant_valid = r_grant_valid;
   assign grant_ch = r_grant_ch;
   assign grant_flush = r_grant_flush;
   assign grant_tag = r_grant_tag;
   assign grant_set = r_grant_set;
   assign grant_way = r_grant_way;
   assign starve_boost = r_boost;
   assign idle = decode_en & ~|w_win & ~w_accept & ~w_flush_op;
endmodule

// File: tb/tb_l2_input_arbiter_param.sv
// tb_l2_input_arbiter_param: directed vector table plus flush/ageing/reset sequences
module tb_l2_input_arbiter_param;
   localparam int N_CH = 4;
   localparam int ADDR_W = 32;
   logic clk = 1'b0;
   logic rst, decode_en, flush_start, flush_ready, flush_active, flush_done;
   logic grant_valid, grant_flush, starve_boost, idle;
   logic [N_CH-1:0] in_valid, in_block, in_ready, grant_ch;
   logic [N_CH*ADDR_W-1:0] in_addr;
   logic [25:0] grant_tag;
   logic [1:0] grant_set;
   logic [0:0] grant_way;
   int n_pass = 0, n_total = 0;
   logic [31:0] addrs [N_CH];
   typedef struct packed {
      logic       en;
      logic [3:0] v;
      logic [3:0] b;
      logic [3:0] rdy;
      logic       idl;
      logic       gv;
      logic [3:0] gch;
   } vec_t;
   vec_t tbl [9];
   l2_input_arbiter_param #(.N_CH(N_CH), .ADDR_W(ADDR_W), .OFF_BITS(4), .SET_BITS(2), .WAYS(2),
                            .FLUSH_PRIO(2), .STARVE_MAX(15)) dut (
      .clk(clk), .rst(rst), .decode_en(decode_en), .in_valid(in_valid), .in_block(in_block),
      .in_addr(in_addr), .in_ready(in_ready), .flush_start(flush_start), .flush_ready(flush_ready),
      .flush_active(flush_active), .flush_done(flush_done), .grant_valid(grant_valid),
      .grant_ch(grant_ch), .grant_flush(grant_flush), .grant_tag(grant_tag), .grant_set(grant_set),
      .grant_way(grant_way), .starve_boost(starve_boost), .idle(idle));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b0;
      decode_en = 1'b0;
      in_valid = '0;
      in_block = '0;
      flush_start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask
   task automatic start_flush();
      decode_en = 1'b1;
      flush_start = 1'b1;
      @(negedge clk);
      chk("accept_ready", flush_ready, 1);
      cyc();
      flush_start = 1'b0;
   endtask
   initial begin
      int idx;
      addrs[0] = 32'h1234_5670;
      addrs[1] = 32'hABCD_EF90;
      addrs[2] = 32'h0F0F_F0E0;
      addrs[3] = 32'hDEAD_BEB0;
      in_addr = {addrs[3], addrs[2], addrs[1], addrs[0]};
      //            en    valid    block    ready    idle  gv    prev gch
      tbl[0] = '{1'b1, 4'b0110, 4'b0000, 4'b0010, 1'b0, 1'b0, 4'b0000};
      tbl[1] = '{1'b1, 4'b0110, 4'b0010, 4'b0100, 1'b0, 1'b1, 4'b0010};
      tbl[2] = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b1, 4'b0100};
      tbl[3] = '{1'b1, 4'b1111, 4'b0001, 4'b0010, 1'b0, 1'b1, 4'b0001};
      tbl[4] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0010};
      tbl[5] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000};
      tbl[6] = '{1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000};
      tbl[7] = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1000};
      tbl[8] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000};
      do_reset();
      for (int k = 0; k < 9; k++) begin
         decode_en = tbl[k].en;
         in_valid = tbl[k].v;
         in_block = tbl[k].b;
         @(negedge clk);
         chk($sformatf("vec%0d_ready", k), in_ready, tbl[k].rdy);
         chk($sformatf("vec%0d_idle", k), idle, tbl[k].idl);
         chk($sformatf("vec%0d_gvalid", k), grant_valid, tbl[k].gv);
         chk($sformatf("vec%0d_gch", k), grant_ch, tbl[k].gch);
         chk($sformatf("vec%0d_boost", k), starve_boost, 0);
         if (tbl[k].gv) begin
            idx = 0;
            for (int c = 0; c < N_CH; c++) if (tbl[k].gch[c]) idx = c;
            chk($sformatf("vec%0d_tag", k), grant_tag, addrs[idx] >> 6);
            chk($sformatf("vec%0d_set", k), grant_set, (addrs[idx] >> 4) & 3);
         end
         cyc();
      end
      // ageing: ch3 loses to ch0 for 15 cycles, then the override fires
      do_reset();
      decode_en = 1'b1;
      in_valid = 4'b1001;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         chk($sformatf("age_lose%0d", k), in_ready, 4'b0001);
         cyc();
      end
      @(negedge clk);
      chk("age_boost_ready", in_ready, 4'b1000);
      cyc();
      @(negedge clk);
      chk("age_boost_flag", starve_boost, 1);
      chk("age_boost_gch", grant_ch, 4'b1000);
      chk("age_cleared_ready", in_ready, 4'b0001);
      cyc();
      @(negedge clk);
      chk("age_boost_off", starve_boost, 0);
      // plain flush walk with no channels
      do_reset();
      in_valid = '0;
      start_flush();
      for (int k = 0; k < 8; k++) begin
         flush_start = (k == 2);
         @(negedge clk);
         chk($sformatf("walk%0d_active", k), flush_active, 1);
         chk($sformatf("walk%0d_fready", k), flush_ready, 0);
         chk($sformatf("walk%0d_idle", k), idle, 0);
         chk($sformatf("walk%0d_gvalid", k), grant_valid, k > 0);
         if (k > 0) begin
            chk($sformatf("walk%0d_gflush", k), grant_flush, 1);
            chk($sformatf("walk%0d_set", k), grant_set, (k - 1) >> 1);
            chk($sformatf("walk%0d_way", k), grant_way, (k - 1) & 1);
            chk($sformatf("walk%0d_gch", k), grant_ch, 0);
         end
         cyc();
      end
      flush_start = 1'b0;
      @(negedge clk);
      chk("walk_done", flush_done, 1);
      chk("walk_done_active", flush_active, 0);
      chk("walk_last_set", grant_set, 3);
      chk("walk_last_way", grant_way, 1);
      cyc();
      @(negedge clk);
      chk("walk_done_pulse", flush_done, 0);
      chk("walk_after_gvalid", grant_valid, 0);
      // preemption and pause during flush
      do_reset();
      start_flush();
      repeat (2) begin
         @(negedge clk);
         cyc();
      end
      in_valid = 4'b0110;
      @(negedge clk);
      chk("pre_ready_ch1", in_ready, 4'b0010);
      cyc();
      in_valid = 4'b0100;
      @(negedge clk);
      chk("pre_ready_ch2_masked", in_ready, 4'b0000);
      chk("pre_gch", grant_ch, 4'b0010);
      chk("pre_gflush", grant_flush, 0);
      chk("pre_tag", grant_tag, addrs[1] >> 6);
      chk("pre_set", grant_set, (addrs[1] >> 4) & 3);
      cyc();
      decode_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("pause%0d_ready", k), in_ready, 0);
         chk($sformatf("pause%0d_idle", k), idle, 0);
         chk($sformatf("pause%0d_set", k), grant_set, 1);
         chk($sformatf("pause%0d_way", k), grant_way, 0);
         chk($sformatf("pause%0d_gflush", k), grant_flush, 1);
         cyc();
      end
      decode_en = 1'b1;
      @(negedge clk);
      chk("resume_ready", in_ready, 0);
      cyc();
      @(negedge clk);
      chk("resume_set", grant_set, 1);
      chk("resume_way", grant_way, 1);
      cyc();
      repeat (3) begin
         @(negedge clk);
         cyc();
      end
      @(negedge clk);
      chk("pre_done", flush_done, 1);
      chk("pre_ch2_ready", in_ready, 4'b0100);
      cyc();
      @(negedge clk);
      chk("pre_ch2_gch", grant_ch, 4'b0100);
      // asynchronous reset in the middle of the walk
      do_reset();
      in_valid = '0;
      start_flush();
      repeat (5) begin
         @(negedge clk);
         cyc();
      end
      @(negedge clk);
      chk("mid_set", grant_set, 2);
      chk("mid_way", grant_way, 0);
      decode_en = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("rst_gvalid", grant_valid, 0);
      chk("rst_gflush", grant_flush, 0);
      chk("rst_set", grant_set, 0);
      chk("rst_active", flush_active, 0);
      chk("rst_done", flush_done, 0);
      chk("rst_ready", {in_ready, flush_ready, idle}, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      decode_en = 1'b1;
      flush_start = 1'b1;
      @(negedge clk);
      chk("restart_fready", flush_ready, 1);
      chk("restart_no_done", flush_done, 0);
      cyc();
      flush_start = 1'b0;
      @(negedge clk);
      chk("restart_active", flush_active, 1);
      cyc();
      @(negedge clk);
      chk("restart_gflush", grant_flush, 1);
      chk("restart_set", grant_set, 0);
      chk("restart_way", grant_way, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
